// File: rtl/simple_pipe.sv
// -----------------------------------------------------------------------------
// simple_pipe
//
// Multi-lane timing-benchmark pipeline with programmable latency. Each lane
// ANDs two inputs into a self-clearing toggle flop, and the flop feeds a
// DEPTH-stage register delay line. The output is taken from a runtime-selected
// stage, optionally inverted. A global enable stalls the whole block.
//
// Parameters
//   LANES   number of independent lanes (>=1)
//   DEPTH   delay-line stages after the toggle flop (>=1)
//   INVERT  1 = outputs inverted relative to the tapped stage
//   TW      tap-select width, derived from DEPTH
//
// Ports
//   tau2015_clk    in   1      rising-edge clock
//   tau2015_rst_n  in   1      synchronous active-low reset
//   inp1           in   LANES  gate input A per lane
//   inp2           in   LANES  gate input B per lane
//   en             in   1      advance enable, 0 holds all state
//   tap            in   TW     output stage select, values above DEPTH clamp
//   out            out  LANES  tapped, optionally inverted lane value
// -----------------------------------------------------------------------------
module simple_pipe #(
    parameter  int LANES  = 4,
    parameter  int DEPTH  = 16,
    parameter  int INVERT = 0,
    localparam int TW     = $clog2(DEPTH + 1)
) (
    input  logic             tau2015_clk,
    input  logic             tau2015_rst_n,
    input  logic [LANES-1:0] inp1,
    input  logic [LANES-1:0] inp2,
    input  logic             en,
    input  logic [TW-1:0]    tap,
    output logic [LANES-1:0] out
);

    // r_stage[0] is the toggle flop itself; r_stage[1..DEPTH] is the delay line.
    logic [LANES-1:0] r_stage [0:DEPTH];

    logic [TW-1:0]    w_tap_sel;
    logic [LANES-1:0] w_inv_mask;

    always_ff @(posedge tau2015_clk) begin
        if (!tau2015_rst_n) begin
            for (int k = 0; k <= DEPTH; k++) begin
                r_stage[k] <= '0;
            end
        end else if (en) begin
            // NAND/NOR feedback law collapses to: set only when both inputs
            // are high and the flop is currently low.
            r_stage[0] <= inp1 & inp2 & ~r_stage[0];
            for (int k = 1; k <= DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    // Out-of-range taps are clamped so the mux never indexes past the line.
    always_comb begin
        w_tap_sel = tap;
        if (tap > TW'(DEPTH)) begin
            w_tap_sel = TW'(DEPTH);
        end
    end

    assign w_inv_mask = (INVERT != 0) ? {LANES{1'b1}} : {LANES{1'b0}};

    // Mux reads registers only, so out never sees inp1/inp2 combinationally.
    assign out = r_stage[w_tap_sel] ^ w_inv_mask;

endmodule

// File: tb/tb_simple_pipe.sv
module tb_simple_pipe;

    localparam int LANES = 4;
    localparam int DEPTH = 16;
    localparam int TW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [LANES-1:0] inp1;
    logic [LANES-1:0] inp2;
    logic             en;
    logic [TW-1:0]    tap;
    logic [LANES-1:0] out_n;
    logic [LANES-1:0] out_i;

    logic [LANES-1:0] exp_q [$];
    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    simple_pipe #(.LANES(LANES), .DEPTH(DEPTH), .INVERT(0)) dut (
        .tau2015_clk   (clk),
        .tau2015_rst_n (rst_n),
        .inp1          (inp1),
        .inp2          (inp2),
        .en            (en),
        .tap           (tap),
        .out           (out_n)
    );

    simple_pipe #(.LANES(LANES), .DEPTH(DEPTH), .INVERT(1)) dut_inv (
        .tau2015_clk   (clk),
        .tau2015_rst_n (rst_n),
        .inp1          (inp1),
        .inp2          (inp2),
        .en            (en),
        .tap           (tap),
        .out           (out_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        inp1  = '0;
        inp2  = '0;
        en    = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [LANES-1:0] e;
        rst_n = 1'b0;
        en    = 1'b1;
        inp1  = '1;
        inp2  = '1;
        tap   = '0;
        exp_q.push_back('0);
        tick(); tick(); tick();
        e = exp_q.pop_front();
        tests_run++;
        if (out_n !== e) begin
            tests_failed++;
            $display("FAIL reset_out got=%b want=%b", out_n, e);
        end
        tests_run++;
        if (out_i !== ~e) begin
            tests_failed++;
            $display("FAIL reset_out_inv got=%b want=%b", out_i, ~e);
        end
        rst_n = 1'b1;
        inp1  = '0;
        inp2  = '0;
        for (int n = 1; n <= 20; n++) begin
            tap = TW'(n % (DEPTH + 1));
            exp_q.push_back('0);
            tick();
            e = exp_q.pop_front();
            tests_run++;
            if (out_n !== e) begin
                tests_failed++;
                $display("FAIL idle_zero cyc=%0d got=%b want=%b", n, out_n, e);
            end
            tests_run++;
            if (out_i !== ~e) begin
                tests_failed++;
                $display("FAIL idle_inv cyc=%0d got=%b want=%b", n, out_i, ~e);
            end
        end
    endtask

    // Lane 0 has both inputs high; lanes 1 and 2 have only one input high.
    task automatic test_toggle(input int tap_val);
        logic [LANES-1:0] e;
        do_reset();
        tap  = TW'(tap_val);
        inp1 = 4'b0011;
        inp2 = 4'b0101;
        for (int n = 1; n <= 24; n++) begin
            e = ((n > tap_val) && (((n - tap_val) % 2) == 1)) ? 4'b0001 : 4'b0000;
            exp_q.push_back(e);
            tick();
            e = exp_q.pop_front();
            tests_run++;
            if (out_n !== e) begin
                tests_failed++;
                $display("FAIL toggle_tap%0d cyc=%0d got=%b want=%b", tap_val, n, out_n, e);
            end
            tests_run++;
            if (out_i !== ~e) begin
                tests_failed++;
                $display("FAIL toggle_inv_tap%0d cyc=%0d got=%b want=%b", tap_val, n, out_i, ~e);
            end
        end
    endtask

    // Single-cycle pulse on lane 2 must appear at the deepest stage once.
    task automatic test_pulse(input int tap_val);
        logic [LANES-1:0] e;
        do_reset();
        tap = TW'(tap_val);
        for (int n = 1; n <= 24; n++) begin
            inp1 = (n == 1) ? 4'b0100 : 4'b0000;
            inp2 = (n == 1) ? 4'b0100 : 4'b0000;
            exp_q.push_back((n == DEPTH + 1) ? 4'b0100 : 4'b0000);
            tick();
            e = exp_q.pop_front();
            tests_run++;
            if (out_n !== e) begin
                tests_failed++;
                $display("FAIL pulse_tap%0d cyc=%0d got=%b want=%b", tap_val, n, out_n, e);
            end
            tests_run++;
            if (out_i !== ~e) begin
                tests_failed++;
                $display("FAIL pulse_inv_tap%0d cyc=%0d got=%b want=%b", tap_val, n, out_i, ~e);
            end
        end
    endtask

    // Pulse on lane 1 with en low on edges 2..5; q holds 1 during the stall.
    task automatic test_stall();
        logic [LANES-1:0] e;
        do_reset();
        tap = TW'(3);
        for (int n = 1; n <= 12; n++) begin
            inp1 = (n == 1) ? 4'b0010 : 4'b0000;
            inp2 = (n == 1) ? 4'b0010 : 4'b0000;
            en   = (n >= 2 && n <= 5) ? 1'b0 : 1'b1;
            exp_q.push_back((n == 8) ? 4'b0010 : 4'b0000);
            tick();
            e = exp_q.pop_front();
            tests_run++;
            if (out_n !== e) begin
                tests_failed++;
                $display("FAIL stall cyc=%0d got=%b want=%b", n, out_n, e);
            end
            tests_run++;
            if (out_i !== ~e) begin
                tests_failed++;
                $display("FAIL stall_inv cyc=%0d got=%b want=%b", n, out_i, ~e);
            end
            if (n == 3) begin
                for (int t = 0; t <= 3; t++) begin
                    tap = TW'(t);
                    exp_q.push_back((t == 0) ? 4'b0010 : 4'b0000);
                    #1;
                    e = exp_q.pop_front();
                    tests_run++;
                    if (out_n !== e) begin
                        tests_failed++;
                        $display("FAIL stall_sweep tap=%0d got=%b want=%b", t, out_n, e);
                    end
                    tests_run++;
                    if (out_i !== ~e) begin
                        tests_failed++;
                        $display("FAIL stall_sweep_inv tap=%0d got=%b want=%b", t, out_i, ~e);
                    end
                end
                tap = TW'(3);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_reset_midstream();
        logic [LANES-1:0] e;
        do_reset();
        tap  = TW'(4);
        inp1 = 4'b1001;
        inp2 = 4'b1001;
        for (int n = 1; n <= 8; n++) begin
            exp_q.push_back(((n > 4) && (((n - 4) % 2) == 1)) ? 4'b1001 : 4'b0000);
            tick();
            e = exp_q.pop_front();
            tests_run++;
            if (out_n !== e) begin
                tests_failed++;
                $display("FAIL midstream_pre cyc=%0d got=%b want=%b", n, out_n, e);
            end
        end
        rst_n = 1'b0;
        en    = 1'b1;
        exp_q.push_back(4'b0000);
        tick();
        e = exp_q.pop_front();
        tests_run++;
        if (out_n !== e) begin
            tests_failed++;
            $display("FAIL midstream_reset got=%b want=%b", out_n, e);
        end
        tests_run++;
        if (out_i !== ~e) begin
            tests_failed++;
            $display("FAIL midstream_reset_inv got=%b want=%b", out_i, ~e);
        end
        rst_n = 1'b1;
        inp1  = '0;
        inp2  = '0;
        for (int n = 1; n <= 20; n++) begin
            tap = TW'(n % (DEPTH + 1));
            exp_q.push_back(4'b0000);
            tick();
            e = exp_q.pop_front();
            tests_run++;
            if (out_n !== e) begin
                tests_failed++;
                $display("FAIL midstream_stale cyc=%0d tap=%0d got=%b want=%b", n, tap, out_n, e);
            end
            tests_run++;
            if (out_i !== ~e) begin
                tests_failed++;
                $display("FAIL midstream_stale_inv cyc=%0d tap=%0d got=%b want=%b", n, tap, out_i, ~e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        inp1  = '0;
        inp2  = '0;
        en    = 1'b1;
        tap   = '0;
        test_reset();
        test_toggle(0);
        test_toggle(5);
        test_pulse(DEPTH);
        test_pulse(31);
        test_stall();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
